// File: rtl/sync_pipeline_ctrl.sv
module sync_pipeline_ctrl #(
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int RW    = 5,
  parameter int GW    = 6,
  parameter int BW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                        clk_25,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic [XW+YW+23:0]           q,
  input  logic                        rdempty,
  output logic                        rdclk,
  output logic                        rdreq,
  output logic [XW-1:0]               query_x,
  output logic [YW-1:0]               query_y,
  output logic                        start,
  input  logic [XW-1:0]               return_x,
  input  logic [YW-1:0]               return_y,
  input  logic [RW-1:0]               r,
  input  logic [GW-1:0]               g,
  input  logic [BW-1:0]               b,
  input  logic                        ready,
  output logic                        val,
  output logic [XW-1:0]               sync_x,
  output logic [YW-1:0]               sync_y,
  output logic [RW-1:0]               dvi_r,
  output logic [GW-1:0]               dvi_g,
  output logic [BW-1:0]               dvi_b,
  output logic [RW-1:0]               ccd_r,
  output logic [GW-1:0]               ccd_g,
  output logic [BW-1:0]               ccd_b,
  output logic [$clog2(DEPTH+1)-1:0]  inflight,
  output logic [15:0]                 mismatch_cnt,
  output logic                        err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [RW-1:0] r;
    logic [GW-1:0] g;
    logic [BW-1:0] b;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          in_entry;
  entry_t          head;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [CW-1:0]   drain_q, drain_d;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   credit_ret;
  logic            rd_pend_q, rd_pend_d;
  logic            push, pop;

  logic            start_q, start_d;
  logic [XW-1:0]   query_x_q, query_x_d;
  logic [YW-1:0]   query_y_q, query_y_d;
  logic            val_q, val_d;
  logic [XW-1:0]   sync_x_q, sync_x_d;
  logic [YW-1:0]   sync_y_q, sync_y_d;
  logic [RW-1:0]   dvi_r_q, dvi_r_d;
  logic [GW-1:0]   dvi_g_q, dvi_g_d;
  logic [BW-1:0]   dvi_b_q, dvi_b_d;
  logic [RW-1:0]   ccd_r_q, ccd_r_d;
  logic [GW-1:0]   ccd_g_q, ccd_g_d;
  logic [BW-1:0]   ccd_b_q, ccd_b_d;
  logic [15:0]     mismatch_q, mismatch_d;
  logic            err_q, err_d;

  logic            unused_q_bits;

  // Colour LSBs below the output widths are dropped by truncation.
  assign unused_q_bits = ^q;

  always_comb begin
    in_entry.x = q[XW+YW+23 -: XW];
    in_entry.y = q[YW+23 -: YW];
    in_entry.r = q[23 -: RW];
    in_entry.g = q[15 -: GW];
    in_entry.b = q[7 -: BW];
  end

  assign head        = mem_q[rd_ptr_q];
  assign outstanding = drain_q + count_q;
  assign rdreq       = !rdempty && (credits_q != '0) && !clear && (drain_q == '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drain_d    = drain_q;
    rd_pend_d  = rdreq;
    push       = 1'b0;
    pop        = 1'b0;
    credit_ret = '0;
    start_d    = 1'b0;
    query_x_d  = query_x_q;
    query_y_d  = query_y_q;
    val_d      = 1'b0;
    sync_x_d   = sync_x_q;
    sync_y_d   = sync_y_q;
    dvi_r_d    = dvi_r_q;
    dvi_g_d    = dvi_g_q;
    dvi_b_d    = dvi_b_q;
    ccd_r_d    = ccd_r_q;
    ccd_g_d    = ccd_g_q;
    ccd_b_d    = ccd_b_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;

    if (clear) begin
      // Queued entries become drain debt; a ready in this cycle settles one
      // of them, and a word read last cycle is dropped with its credit.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      mismatch_d = '0;
      err_d      = 1'b0;
      drain_d    = outstanding;
      if (ready && (outstanding != '0)) begin
        drain_d    = outstanding - CW'(1);
        credit_ret = credit_ret + CW'(1);
      end
      if (rd_pend_q) begin
        credit_ret = credit_ret + CW'(1);
      end
    end else begin
      if (rd_pend_q) begin
        push      = 1'b1;
        start_d   = 1'b1;
        query_x_d = in_entry.x;
        query_y_d = in_entry.y;
      end
      if (ready) begin
        if (drain_q != '0) begin
          drain_d    = drain_q - CW'(1);
          credit_ret = CW'(1);
        end else if (count_q != '0) begin
          pop        = 1'b1;
          val_d      = 1'b1;
          sync_x_d   = return_x;
          sync_y_d   = return_y;
          dvi_r_d    = head.r;
          dvi_g_d    = head.g;
          dvi_b_d    = head.b;
          ccd_r_d    = r;
          ccd_g_d    = g;
          ccd_b_d    = b;
          credit_ret = CW'(1);
          if (((head.x != return_x) || (head.y != return_y)) && (mismatch_q != '1)) begin
            mismatch_d = mismatch_q + 16'd1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    credits_d = credits_q - CW'(rdreq) + credit_ret;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credits_q  <= CW'(DEPTH);
      drain_q    <= '0;
      rd_pend_q  <= 1'b0;
      start_q    <= 1'b0;
      query_x_q  <= '0;
      query_y_q  <= '0;
      val_q      <= 1'b0;
      sync_x_q   <= '0;
      sync_y_q   <= '0;
      dvi_r_q    <= '0;
      dvi_g_q    <= '0;
      dvi_b_q    <= '0;
      ccd_r_q    <= '0;
      ccd_g_q    <= '0;
      ccd_b_q    <= '0;
      mismatch_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credits_q  <= credits_d;
      drain_q    <= drain_d;
      rd_pend_q  <= rd_pend_d;
      start_q    <= start_d;
      query_x_q  <= query_x_d;
      query_y_q  <= query_y_d;
      val_q      <= val_d;
      sync_x_q   <= sync_x_d;
      sync_y_q   <= sync_y_d;
      dvi_r_q    <= dvi_r_d;
      dvi_g_q    <= dvi_g_d;
      dvi_b_q    <= dvi_b_d;
      ccd_r_q    <= ccd_r_d;
      ccd_g_q    <= ccd_g_d;
      ccd_b_q    <= ccd_b_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_25) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign rdclk        = clk_25;
  assign start        = start_q;
  assign query_x      = query_x_q;
  assign query_y      = query_y_q;
  assign val          = val_q;
  assign sync_x       = sync_x_q;
  assign sync_y       = sync_y_q;
  assign dvi_r        = dvi_r_q;
  assign dvi_g        = dvi_g_q;
  assign dvi_b        = dvi_b_q;
  assign ccd_r        = ccd_r_q;
  assign ccd_g        = ccd_g_q;
  assign ccd_b        = ccd_b_q;
  assign inflight     = count_q;
  assign mismatch_cnt = mismatch_q;
  assign err          = err_q;

endmodule
